// File: rtl/zap_ram_simple_ben.sv
// zap_ram_simple_ben: single-port-write / single-port-read RAM with per-byte
// write enables, clear-on-reset INIT sequence, write-first bypass and an
// optional extra output register stage (OUT_REG).
// Optional feature macro: ZAP_RAM_PARITY_EN adds one even-parity bit per byte
// and the o_parity_err output.
module zap_ram_simple_ben #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH/8-1:0]       i_wr_ben,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_init_done
`ifdef ZAP_RAM_PARITY_EN
  ,
  output logic                     o_parity_err
`endif
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_init_done;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_ready;
  logic [NB-1:0]    w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;
  logic             w_rd_fire;
  logic [WIDTH-1:0] w_rd_word;

  logic             r_vld1;
  logic [WIDTH-1:0] r_data1;

`ifdef ZAP_RAM_PARITY_EN
  logic [NB-1:0]    r_par [DEPTH];
  logic [NB-1:0]    w_wr_par;
  logic [NB-1:0]    w_rd_par;
  logic             w_rd_perr;
  logic             r_perr1;
`endif

  // Clear sequencer: INIT walks every address once, then parks in READY
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      if (r_clr_cnt == AW'(DEPTH - 1)) begin
        r_state     <= S_READY;
        r_init_done <= 1'b1;
      end else begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end
    end
  end

  assign w_ready     = (r_state == S_READY);
  assign o_init_done = r_init_done;

  // Write port mux: INIT clear writes take priority over user writes
  always_comb begin
    w_mem_we   = '0;
    w_mem_addr = i_wr_addr;
    w_mem_data = i_wr_data;
    if (!w_ready) begin
      w_mem_we   = '1;
      w_mem_addr = r_clr_cnt;
      w_mem_data = '0;
    end else if (i_wr_en) begin
      w_mem_we = i_wr_ben;
    end
  end

  // Storage array; never touched by reset directly
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_mem_we[k]) begin
        r_mem[w_mem_addr][8*k +: 8] <= w_mem_data[8*k +: 8];
      end
    end
  end

`ifdef ZAP_RAM_PARITY_EN
  // Even parity per byte of the word being written
  always_comb begin
    w_wr_par = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      w_wr_par[k] = ^w_mem_data[8*k +: 8];
    end
  end

  // Parity storage, written alongside the data bytes
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_mem_we[k]) begin
        r_par[w_mem_addr][k] <= w_wr_par[k];
      end
    end
  end
`endif

  assign w_rd_fire = w_ready && i_rd_en;

  // Write-first read merge: enabled bytes of a same-address write bypass the array
  always_comb begin
    w_rd_word = r_mem[i_rd_addr];
`ifdef ZAP_RAM_PARITY_EN
    w_rd_par  = r_par[i_rd_addr];
    w_rd_perr = 1'b0;
`endif
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_ready && i_wr_en && i_wr_ben[k] && (i_wr_addr == i_rd_addr)) begin
        w_rd_word[8*k +: 8] = i_wr_data[8*k +: 8];
`ifdef ZAP_RAM_PARITY_EN
        w_rd_par[k]         = w_wr_par[k];
`endif
      end
    end
`ifdef ZAP_RAM_PARITY_EN
    for (int unsigned k = 0; k < NB; k++) begin
      if ((^w_rd_word[8*k +: 8]) != w_rd_par[k]) begin
        w_rd_perr = 1'b1;
      end
    end
`endif
  end

  // First read stage: capture data at issue so later writes cannot disturb it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld1  <= 1'b0;
      r_data1 <= '0;
`ifdef ZAP_RAM_PARITY_EN
      r_perr1 <= 1'b0;
`endif
    end else begin
      r_vld1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_data1 <= w_rd_word;
      end
`ifdef ZAP_RAM_PARITY_EN
      r_perr1 <= w_rd_fire && w_rd_perr;
`endif
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_vld2;
    logic [WIDTH-1:0] r_data2;
`ifdef ZAP_RAM_PARITY_EN
    logic             r_perr2;
`endif

    // Optional second stage, advances every cycle for full throughput
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_vld2  <= 1'b0;
        r_data2 <= '0;
`ifdef ZAP_RAM_PARITY_EN
        r_perr2 <= 1'b0;
`endif
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_data2 <= r_data1;
        end
`ifdef ZAP_RAM_PARITY_EN
        r_perr2 <= r_vld1 && r_perr1;
`endif
      end
    end

    assign o_rd_valid   = r_vld2;
    assign o_rd_data    = r_data2;
`ifdef ZAP_RAM_PARITY_EN
    assign o_parity_err = r_perr2;
`endif
  end else begin : g_no_out_reg
    assign o_rd_valid   = r_vld1;
    assign o_rd_data    = r_data1;
`ifdef ZAP_RAM_PARITY_EN
    assign o_parity_err = r_perr1;
`endif
  end

endmodule

// File: tb/tb_zap_ram_simple_ben.sv
// Directed bench for zap_ram_simple_ben: two instances (OUT_REG=0 as dut_a,
// OUT_REG=1 as dut_b) share one stimulus stream and are checked side by side.
module tb_zap_ram_simple_ben;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_ben;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;

  logic [31:0] data_a, data_b;
  logic        vld_a, vld_b;
  logic        done_a, done_b;
`ifdef ZAP_RAM_PARITY_EN
  logic        perr_a, perr_b;
`endif

  int errors = 0;
  int checks = 0;

  zap_ram_simple_ben #(.WIDTH(32), .DEPTH(32), .OUT_REG(0)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_ben(wr_ben),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .i_rd_addr(rd_addr), .o_rd_data(data_a), .o_rd_valid(vld_a),
    .o_init_done(done_a)
`ifdef ZAP_RAM_PARITY_EN
    , .o_parity_err(perr_a)
`endif
  );

  zap_ram_simple_ben #(.WIDTH(32), .DEPTH(32), .OUT_REG(1)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_ben(wr_ben),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .i_rd_addr(rd_addr), .o_rd_data(data_b), .o_rd_valid(vld_b),
    .o_init_done(done_b)
`ifdef ZAP_RAM_PARITY_EN
    , .o_parity_err(perr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_ben = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Single read: dut_a answers one cycle after issue, dut_b two cycles after
  task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp,
                         input logic exp_perr);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_a_vld"}, 32'(vld_a), 32'd1);
    check({tag, "_a_data"}, data_a, exp);
    check({tag, "_b_vld_early"}, 32'(vld_b), 32'd0);
`ifdef ZAP_RAM_PARITY_EN
    check({tag, "_a_perr"}, 32'(perr_a), 32'(exp_perr));
`endif
    tick();
    check({tag, "_b_vld"}, 32'(vld_b), 32'd1);
    check({tag, "_b_data"}, data_b, exp);
    check({tag, "_a_vld_after"}, 32'(vld_a), 32'd0);
`ifdef ZAP_RAM_PARITY_EN
    check({tag, "_b_perr"}, 32'(perr_b), 32'(exp_perr));
`endif
    if (exp_perr) begin
    end
  endtask

  initial begin
    int bad;
    int n;
    reset = 1'b1; wr_en = 1'b0; wr_ben = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;

    // Reset state
    tick();
    reset = 1'b0;
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_vld_a", 32'(vld_a), 32'd0);
    check("rst_vld_b", 32'(vld_b), 32'd0);
    check("rst_data_a", data_a, 32'h0);
    check("rst_data_b", data_b, 32'h0);

    // INIT lasts 32 cycles; reads requested during INIT are ignored
    rd_en = 1'b1; rd_addr = 5'd3;
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (done_a || done_b || vld_a || vld_b) bad++;
    end
    check("init_quiet", 32'(bad), 32'd0);
    tick();
    check("init_done_a", 32'(done_a), 32'd1);
    check("init_done_b", 32'(done_b), 32'd1);
    check("init_novld_a", 32'(vld_a), 32'd0);
    rd_en = 1'b0;
    tick();
    check("init_novld_b", 32'(vld_b), 32'd0);

    // Every word cleared
    for (int a = 0; a < 32; a++) begin
      do_read("clr", 5'(a), 32'h0, 1'b0);
    end

    // Byte-enable merge
    do_write(5'd5, 32'hDEADBEEF, 4'b1111);
    do_write(5'd5, 32'h11223344, 4'b0101);
    do_read("ben", 5'd5, 32'hDE22BE44, 1'b0);
    do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    do_read("ben0", 5'd5, 32'hDE22BE44, 1'b0);

    // Same-cycle read/write, same address: write-first per byte
    do_write(5'd7, 32'hAABBCCDD, 4'b1111);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h01020304; wr_ben = 4'b1000;
    do_read("wfirst", 5'd7, 32'h01BBCCDD, 1'b0);
    do_read("wfirst_st", 5'd7, 32'h01BBCCDD, 1'b0);

    // Back-to-back reads with a write to addr 1 after its read issues
    do_write(5'd0, 32'h00000100, 4'b1111);
    do_write(5'd1, 32'h00000111, 4'b1111);
    do_write(5'd2, 32'h00000222, 4'b1111);
    rd_en = 1'b1; rd_addr = 5'd0;
    tick();
    check("b2b_a0_vld", 32'(vld_a), 32'd1);
    check("b2b_a0", data_a, 32'h100);
    check("b2b_b_idle", 32'(vld_b), 32'd0);
    rd_addr = 5'd1;
    tick();
    check("b2b_a1_vld", 32'(vld_a), 32'd1);
    check("b2b_a1", data_a, 32'h111);
    check("b2b_b0_vld", 32'(vld_b), 32'd1);
    check("b2b_b0", data_b, 32'h100);
    rd_addr = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h00000999; wr_ben = 4'b1111;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("b2b_a2_vld", 32'(vld_a), 32'd1);
    check("b2b_a2", data_a, 32'h222);
    check("b2b_b1_vld", 32'(vld_b), 32'd1);
    check("b2b_b1", data_b, 32'h111);
    tick();
    check("b2b_a_end_vld", 32'(vld_a), 32'd0);
    check("b2b_a_hold", data_a, 32'h222);
    check("b2b_b2_vld", 32'(vld_b), 32'd1);
    check("b2b_b2", data_b, 32'h222);
    tick();
    check("b2b_b_end_vld", 32'(vld_b), 32'd0);
    check("b2b_b_hold", data_b, 32'h222);
    do_read("b2b_post", 5'd1, 32'h00000999, 1'b0);

`ifdef ZAP_RAM_PARITY_EN
    // Corrupt stored parity of byte 2 at addr 3
    do_write(5'd3, 32'h12345678, 4'b1111);
    do_write(5'd4, 32'h9ABCDEF0, 4'b1111);
    dut_a.r_par[3] = dut_a.r_par[3] ^ 4'b0100;
    dut_b.r_par[3] = dut_b.r_par[3] ^ 4'b0100;
    do_read("par_bad", 5'd3, 32'h12345678, 1'b1);
    do_read("par_ok", 5'd4, 32'h9ABCDEF0, 1'b0);
`endif

    // Reset with a read in flight: no valid emerges
    rd_en = 1'b1; rd_addr = 5'd5;
    tick();
    rd_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("inflt_vld_a", 32'(vld_a), 32'd0);
    check("inflt_vld_b", 32'(vld_b), 32'd0);
    check("inflt_data_b", data_b, 32'h0);
    check("inflt_done", 32'(done_a), 32'd0);

    // Reset again at clear counter 10; INIT restarts from 0
    for (int i = 0; i < 10; i++) tick();
    check("mid_init_done", 32'(done_b), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (n < 40 && !done_b) begin
      tick();
      n++;
      if (vld_a || vld_b) bad++;
    end
    check("reinit_cycles", 32'(n), 32'd32);
    check("reinit_done_a", 32'(done_a), 32'd1);
    do_read("reinit_clr", 5'd5, 32'h0, 1'b0);
    do_read("reinit_clr7", 5'd7, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
